// File: rtl/dot_accum.sv
// Streaming signed dot product of paired query/database vectors, one result word per vector.
// Optional DOT_SAT_EN macro: saturate out-of-range results instead of wrapping.
module dot_accum #(
  parameter int DATA_W  = 16,
  parameter int VEC_LEN = 128,
  parameter int ACC_W   = 48,
  parameter int OUT_W   = 32
) (
  input  logic              bus_clk,
  input  logic              rst_n,
  output logic              fifo_a_rden,
  input  logic              fifo_a_empty,
  input  logic [DATA_W-1:0] fifo_a_dout,
  output logic              fifo_b_rden,
  input  logic              fifo_b_empty,
  input  logic [DATA_W-1:0] fifo_b_dout,
  output logic              fifo_out_wren,
  input  logic              fifo_out_full,
  output logic [OUT_W-1:0]  fifo_out_din,
  output logic              busy,
  output logic [15:0]       frames_done,
  output logic              acc_ovf
);

  localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [CNT_W-1:0]          elem_cnt;
  logic                      drain_cnt;
  logic                      drain_done;
  logic                      pair_rd;
  logic                      write_go;
  logic                      last_pair;
  logic                      rd_v;
  logic                      prod_v;
  logic signed [PROD_W-1:0]  a_ext;
  logic signed [PROD_W-1:0]  b_ext;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic                      acc_first;

  // True when v is representable as a signed OUT_W value.
  function automatic logic fits_out(input logic signed [ACC_W-1:0] v);
    return (v[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){v[ACC_W-1]}});
  endfunction

  function automatic logic [OUT_W-1:0] to_result(input logic signed [ACC_W-1:0] v);
    logic [OUT_W-1:0] r;
`ifdef DOT_SAT_EN
    if (fits_out(v)) begin
      r = v[OUT_W-1:0];
    end else if (v[ACC_W-1]) begin
      r = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      r = {1'b0, {(OUT_W-1){1'b1}}};
    end
`else
    r = v[OUT_W-1:0];
`endif
    return r;
  endfunction

  assign last_pair  = (elem_cnt == CNT_W'(VEC_LEN - 1));
  assign drain_done = (state == DRAIN) && drain_cnt;

  // State register.
  always_ff @(posedge bus_clk) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and FIFO strobes; strobes are forced low while reset is asserted.
  always_comb begin
    state_next = state;
    pair_rd    = 1'b0;
    write_go   = 1'b0;
    case (state)
      RUN: begin
        pair_rd = rst_n && !fifo_a_empty && !fifo_b_empty;
        if (pair_rd && last_pair) begin
          state_next = DRAIN;
        end else begin
          state_next = RUN;
        end
      end
      DRAIN: begin
        if (drain_cnt) begin
          state_next = WRITE;
        end else begin
          state_next = DRAIN;
        end
      end
      WRITE: begin
        write_go = rst_n && !fifo_out_full;
        if (write_go) begin
          state_next = RUN;
        end else begin
          state_next = WRITE;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign fifo_a_rden   = pair_rd;
  assign fifo_b_rden   = pair_rd;
  assign fifo_out_wren = write_go;
  assign busy          = (state != RUN) || (elem_cnt != '0);

  assign a_ext    = {{DATA_W{fifo_a_dout[DATA_W-1]}}, fifo_a_dout};
  assign b_ext    = {{DATA_W{fifo_b_dout[DATA_W-1]}}, fifo_b_dout};
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // Accumulator input: the first product of a frame replaces the old sum.
  always_comb begin
    acc_next = acc;
    if (prod_v) begin
      if (acc_first) begin
        acc_next = prod_ext;
      end else begin
        acc_next = acc + prod_ext;
      end
    end else begin
      acc_next = acc;
    end
  end

  // Element counter, drain timer, multiply/accumulate pipeline.
  always_ff @(posedge bus_clk) begin
    if (!rst_n) begin
      elem_cnt  <= '0;
      drain_cnt <= 1'b0;
      rd_v      <= 1'b0;
      prod_v    <= 1'b0;
      prod      <= '0;
      acc       <= '0;
      acc_first <= 1'b1;
    end else begin
      if (pair_rd) begin
        elem_cnt <= last_pair ? '0 : elem_cnt + CNT_W'(1);
      end
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      rd_v      <= pair_rd;
      prod_v    <= rd_v;
      if (rd_v) begin
        prod <= a_ext * b_ext;
      end
      acc <= acc_next;
      if (drain_done) begin
        acc_first <= 1'b1;
      end else if (prod_v) begin
        acc_first <= 1'b0;
      end
    end
  end

  // Result capture on drain exit (includes the final product), overflow flag and frame count.
  always_ff @(posedge bus_clk) begin
    if (!rst_n) begin
      fifo_out_din <= '0;
      acc_ovf      <= 1'b0;
      frames_done  <= 16'd0;
    end else begin
      if (drain_done) begin
        fifo_out_din <= to_result(acc_next);
        if (!fits_out(acc_next)) begin
          acc_ovf <= 1'b1;
        end
      end
      if (write_go) begin
        frames_done <= frames_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dot_accum.sv
// Scoreboard bench for dot_accum (VEC_LEN=4); expected results come from a behavioural model.
module tb_dot_accum;

  logic        bus_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_a_rden, fifo_b_rden;
  logic        fifo_a_empty, fifo_b_empty;
  logic [15:0] fifo_a_dout = 16'd0;
  logic [15:0] fifo_b_dout = 16'd0;
  logic        fifo_out_wren;
  logic        fifo_out_full = 1'b0;
  logic [31:0] fifo_out_din;
  logic        busy;
  logic [15:0] frames_done;
  logic        acc_ovf;

  dot_accum #(.DATA_W(16), .VEC_LEN(4), .ACC_W(48), .OUT_W(32)) dut (
    .bus_clk(bus_clk), .rst_n(rst_n),
    .fifo_a_rden(fifo_a_rden), .fifo_a_empty(fifo_a_empty), .fifo_a_dout(fifo_a_dout),
    .fifo_b_rden(fifo_b_rden), .fifo_b_empty(fifo_b_empty), .fifo_b_dout(fifo_b_dout),
    .fifo_out_wren(fifo_out_wren), .fifo_out_full(fifo_out_full), .fifo_out_din(fifo_out_din),
    .busy(busy), .frames_done(frames_done), .acc_ovf(acc_ovf)
  );

  always #5 bus_clk = ~bus_clk;

  // Input FIFO models: data appears on dout the cycle after rden.
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  int wa = 0, wb = 0, ra = 0, rb = 0;
  assign fifo_a_empty = (wa == ra);
  assign fifo_b_empty = (wb == rb);

  always @(posedge bus_clk) begin
    if (fifo_a_rden) begin
      fifo_a_dout <= mem_a[ra[7:0]];
      ra <= ra + 1;
    end
    if (fifo_b_rden) begin
      fifo_b_dout <= mem_b[rb[7:0]];
      rb <= rb + 1;
    end
  end

  int n_cmp = 0, n_err = 0, cyc = 0;
  int last_rd = 0, last_wr = 0, last_gap = 0;
  bit have_wr = 1'b0;
  bit exp_ovf = 1'b0;
  int exp_frames = 0;
  logic [31:0] exp_q [$];

  task automatic sample();
    n_cmp++;
    if (fifo_a_rden !== fifo_b_rden) begin
      n_err++; $display("FAIL rden_pair: a=%b b=%b required equal (cyc %0d)", fifo_a_rden, fifo_b_rden, cyc);
    end
    n_cmp++;
    if ((fifo_a_rden && fifo_a_empty) || (fifo_b_rden && fifo_b_empty)) begin
      n_err++; $display("FAIL read_empty: rden while empty (cyc %0d)", cyc);
    end
    if (fifo_a_rden) last_rd = cyc;
    if (fifo_out_wren) begin
      n_cmp++;
      if (fifo_out_full) begin
        n_err++; $display("FAIL wren_full: wren=1 while full (cyc %0d)", cyc);
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL unexpected_result: din=%h with empty scoreboard", fifo_out_din);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (fifo_out_din !== e) begin
          n_err++; $display("FAIL result: din=%h required %h", fifo_out_din, e);
        end
      end
      if (have_wr) last_gap = cyc - last_wr;
      last_wr = cyc;
      have_wr = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge bus_clk);
    cyc++;
    sample();
  endtask

  task automatic push_a(input int v);
    mem_a[wa[7:0]] = 16'(v);
    wa++;
  endtask

  task automatic push_b(input int v);
    mem_b[wb[7:0]] = 16'(v);
    wb++;
  endtask

  task automatic expect_frame(input int a0, a1, a2, a3, b0, b1, b2, b3);
    longint s;
    logic [31:0] e;
    s = longint'(a0) * b0 + longint'(a1) * b1 + longint'(a2) * b2 + longint'(a3) * b3;
    e = s[31:0];
    if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
      exp_ovf = 1'b1;
`ifdef DOT_SAT_EN
      e = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    end
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input int a0, a1, a2, a3, b0, b1, b2, b3);
    expect_frame(a0, a1, a2, a3, b0, b1, b2, b3);
    push_a(a0); push_a(a1); push_a(a2); push_a(a3);
    push_b(b0); push_b(b1); push_b(b2); push_b(b3);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 100; i++) begin
      if (frames_done == 16'(target)) break;
      step();
    end
    n_cmp++;
    if (frames_done !== 16'(target)) begin
      n_err++; $display("FAIL frames_done: got %0d required %0d", frames_done, target);
    end
  endtask

  task automatic test_reset();
    step(); step();
    n_cmp += 7;
    if (fifo_a_rden !== 1'b0 || fifo_b_rden !== 1'b0) begin n_err++; $display("FAIL reset_rden: a=%b b=%b required 0", fifo_a_rden, fifo_b_rden); end
    if (fifo_out_wren !== 1'b0) begin n_err++; $display("FAIL reset_wren: got %b required 0", fifo_out_wren); end
    if (fifo_out_din !== 32'd0) begin n_err++; $display("FAIL reset_din: got %h required 0", fifo_out_din); end
    if (frames_done !== 16'd0) begin n_err++; $display("FAIL reset_frames: got %0d required 0", frames_done); end
    if (acc_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b required 0", acc_ovf); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (fifo_a_empty !== 1'b1) begin n_err++; $display("FAIL reset_fifo: empty=%b required 1", fifo_a_empty); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    push_frame(1, 2, 3, 4, 5, 6, 7, 8);
    exp_frames++;
    wait_done(exp_frames);
    n_cmp += 2;
    if (last_wr - last_rd != 3) begin n_err++; $display("FAIL latency: got %0d required 3", last_wr - last_rd); end
    if (acc_ovf !== exp_ovf) begin n_err++; $display("FAIL basic_ovf: got %b required %b", acc_ovf, exp_ovf); end
  endtask

  task automatic test_negative();
    push_frame(-1, -2, -3, -4, 5, 6, 7, 8);
    exp_frames++;
    wait_done(exp_frames);
    n_cmp++;
    if (acc_ovf !== exp_ovf) begin n_err++; $display("FAIL neg_ovf: got %b required %b", acc_ovf, exp_ovf); end
  endtask

  task automatic test_stall();
    expect_frame(1, 2, 3, 4, 5, 6, 7, 8);
    push_a(1); push_a(2); push_a(3); push_a(4);
    push_b(5); push_b(6);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (fifo_a_rden !== 1'b0 || fifo_b_rden !== 1'b0) begin
        n_err++; $display("FAIL stall_rden: a=%b b=%b required 0", fifo_a_rden, fifo_b_rden);
      end
    end
    push_b(7); push_b(8);
    exp_frames++;
    wait_done(exp_frames);
  endtask

  task automatic test_full();
    fifo_out_full = 1'b1;
    push_frame(1, 2, 3, 4, 5, 6, 7, 8);
    push_frame(-1, -2, -3, -4, 5, 6, 7, 8);
    for (int i = 0; i < 7; i++) step();
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp += 3;
      if (fifo_out_wren !== 1'b0) begin n_err++; $display("FAIL full_wren: got %b required 0", fifo_out_wren); end
      if (fifo_out_din !== 32'd70) begin n_err++; $display("FAIL full_din: got %h required %h", fifo_out_din, 32'd70); end
      if (fifo_a_rden !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL full_hold: rden=%b busy=%b required 0/1", fifo_a_rden, busy); end
    end
    fifo_out_full = 1'b0;
    #1;
    n_cmp++;
    if (fifo_out_wren !== 1'b1) begin n_err++; $display("FAIL full_release: wren=%b required 1", fifo_out_wren); end
    sample();
    exp_frames += 2;
    wait_done(exp_frames);
  endtask

  task automatic test_overflow();
    push_frame(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
    exp_frames++;
    wait_done(exp_frames);
    n_cmp++;
    if (acc_ovf !== exp_ovf) begin n_err++; $display("FAIL ovf: got %b required %b", acc_ovf, exp_ovf); end
  endtask

  task automatic test_back_to_back();
    push_frame(1, 2, 3, 4, 5, 6, 7, 8);
    push_frame(100, -200, 300, -400, 7, 7, 7, 7);
    push_frame(32767, 32767, -5, 9, 32767, 32767, 3, -2);
    exp_frames += 3;
    wait_done(exp_frames);
    n_cmp++;
    if (last_gap != 7) begin n_err++; $display("FAIL throughput: gap %0d required 7", last_gap); end
  endtask

  task automatic test_reset_mid();
    push_a(1); push_a(2); push_b(5); push_b(6);
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    push_frame(1, 2, 3, 4, 5, 6, 7, 8);
    exp_ovf = 1'b0;
    exp_frames = 1;
    step();
    n_cmp += 3;
    if (fifo_a_rden !== 1'b0 || fifo_b_rden !== 1'b0 || fifo_out_wren !== 1'b0) begin
      n_err++; $display("FAIL midreset_strobes: rd=%b/%b wr=%b required 0", fifo_a_rden, fifo_b_rden, fifo_out_wren);
    end
    if (frames_done !== 16'd0) begin n_err++; $display("FAIL midreset_frames: got %0d required 0", frames_done); end
    if (acc_ovf !== 1'b0) begin n_err++; $display("FAIL midreset_ovf: got %b required 0", acc_ovf); end
    rst_n = 1'b1;
    wait_done(exp_frames);
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (acc_ovf !== exp_ovf) begin n_err++; $display("FAIL midreset_ovf_after: got %b required %b", acc_ovf, exp_ovf); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_stall();
    test_full();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_leftover: %0d results outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
